// File: rtl/winograd_result_collector.sv
// winograd_result_collector
//   Sits beside the winograd dot-product unit. It sees the same operand beats at
//   issue time and computes the Winograd correction terms
//   ca = sum a[2j]*a[2j+1] and cb = sum b[2j]*b[2j+1]. These travel down a
//   LATENCY-deep pipe, so they line up with the unit's two partial outputs.
//   Each beat's dot product is out[0] + out[1] - ca - cb. Beats are accumulated
//   until the last chunk, and the signed total is presented on a valid/ready port.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   issue_valid_i/_o    operand beat handshake (issue_ready_o low from last beat to result handshake)
//   last_i              beat closes the current dot product
//   in_0_i, in_1_i      8 signed operands each (element i at [i*W +: W])
//   wino_out_i          winograd partials, out[0] in the low OUT_SIZE bits
//   res_valid_o/ready_i result handshake
//   res_o, ovf_o        signed dot product and sticky signed-overflow flag
module winograd_result_collector #(
  parameter int unsigned IN_SIZE_0 = 8,
  parameter int unsigned IN_SIZE_1 = 8,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ACC_SIZE  = 32,
  localparam int unsigned OUT_SIZE = 2 * (IN_SIZE_1 + 1) + 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic                    last_i,
  input  logic [8*IN_SIZE_0-1:0]  in_0_i,
  input  logic [8*IN_SIZE_1-1:0]  in_1_i,
  input  logic [2*OUT_SIZE-1:0]   wino_out_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [ACC_SIZE-1:0]     res_o,
  output logic                    ovf_o
);

  localparam int unsigned CA_W  = 2 * IN_SIZE_0 + 2;
  localparam int unsigned CB_W  = 2 * IN_SIZE_1 + 2;
  localparam int unsigned MAX_A = (ACC_SIZE > OUT_SIZE) ? ACC_SIZE : OUT_SIZE;
  localparam int unsigned MAX_B = (CA_W > CB_W) ? CA_W : CB_W;
  // Headroom wide enough that neither the beat sum nor acc + beat can wrap.
  localparam int unsigned WIDE_W = ((MAX_A > MAX_B) ? MAX_A : MAX_B) + 3;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       issue_ready_q, issue_ready_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic                       ovf_acc_q, ovf_acc_d;
  logic [ACC_SIZE-1:0]        res_q, res_d;
  logic                       res_ovf_q, res_ovf_d;
  logic                       res_valid_q, res_valid_d;

  logic                       pipe_valid_q [LATENCY];
  logic                       pipe_valid_d [LATENCY];
  logic                       pipe_last_q  [LATENCY];
  logic                       pipe_last_d  [LATENCY];
  logic signed [CA_W-1:0]     pipe_ca_q    [LATENCY];
  logic signed [CA_W-1:0]     pipe_ca_d    [LATENCY];
  logic signed [CB_W-1:0]     pipe_cb_q    [LATENCY];
  logic signed [CB_W-1:0]     pipe_cb_d    [LATENCY];

  logic                       accept_c;
  logic signed [CA_W-1:0]     ca_c;
  logic signed [CB_W-1:0]     cb_c;

  assign accept_c = issue_valid_i & issue_ready_q;

  // Correction terms: sums of adjacent-pair products within each operand vector.
  always_comb begin : corr_terms
    logic signed [IN_SIZE_0-1:0]   a_e, a_o;
    logic signed [IN_SIZE_1-1:0]   b_e, b_o;
    logic signed [2*IN_SIZE_0-1:0] pa;
    logic signed [2*IN_SIZE_1-1:0] pb;
    ca_c = '0;
    cb_c = '0;
    for (int j = 0; j < 4; j++) begin
      a_e  = in_0_i[(2*j)*IN_SIZE_0 +: IN_SIZE_0];
      a_o  = in_0_i[(2*j+1)*IN_SIZE_0 +: IN_SIZE_0];
      b_e  = in_1_i[(2*j)*IN_SIZE_1 +: IN_SIZE_1];
      b_o  = in_1_i[(2*j+1)*IN_SIZE_1 +: IN_SIZE_1];
      pa   = (2*IN_SIZE_0)'(a_e) * (2*IN_SIZE_0)'(a_o);
      pb   = (2*IN_SIZE_1)'(b_e) * (2*IN_SIZE_1)'(b_o);
      ca_c = ca_c + CA_W'(pa);
      cb_c = cb_c + CB_W'(pb);
    end
  end

  // Delay line matching the winograd unit's issue-to-output latency.
  always_comb begin : pipe_next
    pipe_valid_d[0] = accept_c;
    pipe_last_d[0]  = accept_c & last_i;
    pipe_ca_d[0]    = ca_c;
    pipe_cb_d[0]    = cb_c;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_last_d[i]  = pipe_last_q[i-1];
      pipe_ca_d[i]    = pipe_ca_q[i-1];
      pipe_cb_d[i]    = pipe_cb_q[i-1];
    end
  end

  // Accumulate, control FSM and result register.
  always_comb begin : ctrl_next
    logic signed [OUT_SIZE-1:0] out0_s, out1_s;
    logic signed [WIDE_W-1:0]   beat_w, sum_w;
    logic signed [ACC_SIZE-1:0] acc_next;
    logic                       ovf_next;
    logic                       exit_valid, exit_last;

    state_d     = state_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    res_d       = res_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;

    exit_valid = pipe_valid_q[LATENCY-1];
    exit_last  = pipe_last_q[LATENCY-1];
    out0_s     = wino_out_i[OUT_SIZE-1:0];
    out1_s     = wino_out_i[2*OUT_SIZE-1:OUT_SIZE];
    beat_w     = WIDE_W'(out0_s) + WIDE_W'(out1_s)
               - WIDE_W'(pipe_ca_q[LATENCY-1]) - WIDE_W'(pipe_cb_q[LATENCY-1]);
    sum_w      = WIDE_W'(acc_q) + beat_w;
    acc_next   = sum_w[ACC_SIZE-1:0];
    // Overflow when the wrapped sum no longer equals the exact sum.
    ovf_next   = ovf_acc_q | (WIDE_W'(acc_next) != sum_w);

    if (exit_valid) begin
      acc_d     = acc_next;
      ovf_acc_d = ovf_next;
    end

    case (state_q)
      ST_ACC: begin
        if (accept_c && last_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (exit_valid && exit_last) begin
          res_d       = acc_next;
          res_ovf_d   = ovf_next;
          res_valid_d = 1'b1;
          acc_d       = '0;
          ovf_acc_d   = 1'b0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase

    issue_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_ACC;
      issue_ready_q <= 1'b1;
      acc_q         <= '0;
      ovf_acc_q     <= 1'b0;
      res_q         <= '0;
      res_ovf_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_last_q[i]  <= 1'b0;
        pipe_ca_q[i]    <= '0;
        pipe_cb_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      issue_ready_q <= issue_ready_d;
      acc_q         <= acc_d;
      ovf_acc_q     <= ovf_acc_d;
      res_q         <= res_d;
      res_ovf_q     <= res_ovf_d;
      res_valid_q   <= res_valid_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_last_q[i]  <= pipe_last_d[i];
        pipe_ca_q[i]    <= pipe_ca_d[i];
        pipe_cb_q[i]    <= pipe_cb_d[i];
      end
    end
  end

  assign issue_ready_o = issue_ready_q;
  assign res_valid_o   = res_valid_q;
  assign res_o         = res_q;
  assign ovf_o         = res_ovf_q;

endmodule

// File: tb/tb_winograd_result_collector.sv
// Bench for winograd_result_collector. A behavioural stand-in for the winograd
// unit drives wino_out_i exactly LATENCY cycles after each issue and drives random
// values at all other times. Two collectors, with 32-bit and 16-bit accumulators,
// share the same stimulus.
module tb_winograd_result_collector;

  localparam int L  = 3;
  localparam int OS = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, last;
  logic [63:0]   in_0, in_1;
  logic [2*OS-1:0] wino_out;
  logic          res_ready;
  logic          issue_ready32, issue_ready16;
  logic          res_valid32, res_valid16;
  logic [31:0]   res32;
  logic [15:0]   res16;
  logic          ovf32, ovf16;

  longint        cyc = 0;
  logic [2*OS-1:0] wino_map [longint];
  int            n_checks = 0;
  int            n_fail = 0;
  longint        issue_edge;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  winograd_result_collector #(.IN_SIZE_0(8), .IN_SIZE_1(8), .LATENCY(L), .ACC_SIZE(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready32),
    .last_i(last), .in_0_i(in_0), .in_1_i(in_1), .wino_out_i(wino_out),
    .res_valid_o(res_valid32), .res_ready_i(res_ready), .res_o(res32), .ovf_o(ovf32));

  winograd_result_collector #(.IN_SIZE_0(8), .IN_SIZE_1(8), .LATENCY(L), .ACC_SIZE(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready16),
    .last_i(last), .in_0_i(in_0), .in_1_i(in_1), .wino_out_i(wino_out),
    .res_valid_o(res_valid16), .res_ready_i(res_ready), .res_o(res16), .ovf_o(ovf16));

  // Winograd stand-in: the partial output appears during the cycle before the collector samples it.
  always @(negedge clk) begin
    if (wino_map.exists(cyc)) begin
      wino_out = wino_map[cyc];
      wino_map.delete(cyc);
    end else begin
      wino_out = (2*OS)'({$urandom(), $urandom()});
    end
  end

  function automatic longint el(input logic [63:0] v, input int i);
    logic [7:0] e;
    e = v[8*i +: 8];
    return longint'($signed(e));
  endfunction

  // Winograd algorithm: out[k] = sum over pairs j of (a[2j]+b[2j+1])*(a[2j+1]+b[2j]).
  function automatic logic [2*OS-1:0] wino(input logic [63:0] a, input logic [63:0] b);
    longint p0, p1, t;
    p0 = 0; p1 = 0;
    for (int j = 0; j < 4; j++) begin
      t = (el(a, 2*j) + el(b, 2*j+1)) * (el(a, 2*j+1) + el(b, 2*j));
      if (j < 2) p0 += t; else p1 += t;
    end
    return {OS'(p1), OS'(p0)};
  endfunction

  function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += el(a, i) * el(b, i);
    return s;
  endfunction

  function automatic longint wrap(input longint x, input int bits);
    longint m, y;
    m = longint'(1) <<< bits;
    y = x & (m - 1);
    if (y >= (m >>> 1)) y -= m;
    return y;
  endfunction

  // Reference: wrapping accumulation of per-beat dot products with sticky overflow.
  task automatic ref_model(input longint dots[$], input int bits, output longint res, output bit ovf);
    longint acc, t, w;
    acc = 0; ovf = 1'b0;
    foreach (dots[i]) begin
      t = acc + dots[i];
      w = wrap(t, bits);
      if (w != t) ovf = 1'b1;
      acc = w;
    end
    res = acc;
  endtask

  function automatic logic [63:0] vec(input int base, input int step);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(base + step * i);
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one beat at a falling edge; returns at the next falling edge.
  task automatic issue_beat(input logic [63:0] a, input logic [63:0] b, input bit is_last);
    int t = 0;
    while (!issue_ready32 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("issue_ready_timeout", 0, 1);
    in_0 = a; in_1 = b; last = is_last; issue_valid = 1'b1;
    wino_map[cyc + L] = wino(a, b);
    issue_edge = cyc + 1;
    @(negedge clk);
    issue_valid = 1'b0; last = 1'b0;
    in_0 = {$urandom(), $urandom()}; in_1 = {$urandom(), $urandom()};
  endtask

  task automatic wait_result(input bit chk_latency);
    int t = 0;
    while (!res_valid32 && t < L + 30) begin
      @(negedge clk);
      t++;
    end
    check("res_valid_seen", longint'(res_valid32), 1);
    check("res_valid16_seen", longint'(res_valid16), 1);
    if (chk_latency) check("result_latency", cyc, issue_edge + L);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", longint'(res_valid32), 0);
    check("ready_after_handshake", longint'(issue_ready32), 1);
  endtask

  task automatic check_res(input string tag, input longint e32, input bit o32,
                           input longint e16, input bit o16);
    check({tag, "_res32"}, longint'($signed(res32)), e32);
    check({tag, "_ovf32"}, longint'(ovf32), longint'(o32));
    check({tag, "_res16"}, longint'($signed(res16)), e16);
    check({tag, "_ovf16"}, longint'(ovf16), longint'(o16));
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    longint      e32;
    bit          o32;
    longint      e16;
    bit          o16;
  } vec_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    tbl[8];
    longint  dots[$];
    longint  m32, m16, held;
    bit      mo32, mo16, stable_ok, saw;
    int      nb, t;
    logic [63:0] ra, rb;

    tbl[0] = '{vec(0, 1),   vec(1, 0),    28,      1'b0, 28,    1'b0};
    tbl[1] = '{vec(127, 0), vec(127, 0),  129032,  1'b0, -2040, 1'b1};
    tbl[2] = '{vec(1, 0),   vec(2, 0),    16,      1'b0, 16,    1'b0};
    tbl[3] = '{vec(-128,0), vec(-128, 0), 131072,  1'b0, 0,     1'b1};
    tbl[4] = '{vec(2, 0),   vec(3, 0),    48,      1'b0, 48,    1'b0};
    tbl[5] = '{vec(-1, 0),  vec(1, 0),    -8,      1'b0, -8,    1'b0};
    tbl[6] = '{vec(-128,0), vec(127, 0),  -130048, 1'b0, 1024,  1'b1};
    tbl[7] = '{vec(0, 1),   vec(7, -1),   56,      1'b0, 56,    1'b0};

    rst = 1'b1; issue_valid = 1'b0; last = 1'b0; in_0 = '0; in_1 = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", longint'(res_valid32 | res_valid16), 0);
    check("reset_res", longint'(res32) + longint'(res16), 0);
    check("reset_ovf", longint'(ovf32 | ovf16), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", longint'(issue_ready32 & issue_ready16), 1);

    // Single-beat dot products from the table.
    for (int i = 0; i < 8; i++) begin
      issue_beat(tbl[i].a, tbl[i].b, 1'b1);
      wait_result(1'b1);
      check_res($sformatf("tbl%0d", i), tbl[i].e32, tbl[i].o32, tbl[i].e16, tbl[i].o16);
      take_result();
    end

    // Four back-to-back beats, last on the fourth.
    for (int k = 0; k < 4; k++) begin
      check("b2b_ready_before_beat", longint'(issue_ready32), 1);
      issue_beat(vec(-128, 0), vec(-128, 0), k == 3);
    end
    check("b2b_ready_low_after_last", longint'(issue_ready32), 0);
    wait_result(1'b1);
    check("b2b_ready_low_hold", longint'(issue_ready32), 0);
    check_res("b2b", 524288, 1'b0, 0, 1'b1);
    take_result();

    // Downstream back-pressure for 10 cycles.
    issue_beat(vec(3, 0), vec(-5, 0), 1'b1);
    wait_result(1'b1);
    held = longint'($signed(res32));
    stable_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid32 || longint'($signed(res32)) != held || ovf32 || issue_ready32) stable_ok = 1'b0;
    end
    check("hold_stable", longint'(stable_ok), 1);
    check("hold_value", held, -120);
    take_result();
    issue_beat(vec(1, 0), vec(2, 0), 1'b1);
    wait_result(1'b1);
    check_res("after_hold", 16, 1'b0, 16, 1'b0);
    take_result();

    // Reset one cycle after a last beat: no result pulse, then normal operation.
    issue_beat(vec(5, 0), vec(5, 0), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (L + 6) begin
      if (res_valid32 | res_valid16) saw = 1'b1;
      @(negedge clk);
    end
    check("mid_reset_no_pulse", longint'(saw), 0);
    check("mid_reset_res_clear", longint'(res32), 0);
    check("mid_reset_ready", longint'(issue_ready32), 1);
    issue_beat(vec(2, 0), vec(3, 0), 1'b1);
    wait_result(1'b1);
    check_res("post_reset", 48, 1'b0, 48, 1'b0);
    take_result();

    // Random dot products with idle gaps and random downstream ready.
    for (int d = 0; d < 100; d++) begin
      nb = $urandom_range(1, 8);
      dots.delete();
      for (int k = 0; k < nb; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        res_ready = 1'($urandom_range(0, 1));
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        dots.push_back(dot(ra, rb));
        issue_beat(ra, rb, k == nb - 1);
      end
      res_ready = 1'b0;
      wait_result(1'b1);
      ref_model(dots, 32, m32, mo32);
      ref_model(dots, 16, m16, mo16);
      check_res($sformatf("rand%0d", d), m32, mo32, m16, mo16);
      t = 0;
      while (res_valid32 && t < 40) begin
        res_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        t++;
      end
      res_ready = 1'b0;
      check("rand_handshake", longint'(res_valid32), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
